pipe_hazard_ctrl: RTL and testbench

- Central stall/bubble controller for the 5-stage aricriscv pipeline.
- Drives the `*_stall_i` / `*_bubble_i` inputs of the F, D, E, M and W pipeline registers.
- Resolves load-use hazards, branch/jump mispredict flushes, multi-cycle data-memory waits and SYSTEM-instruction halt.
- Keeps stall and flush performance counters. Sits beside the pipeline in the CPU top; its inputs are taken from the stage registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_perf_cnt.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants plus the hazard-controller opcodes and state encoding.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned CPU_WIDTH = 32;
    localparam int unsigned REG_WIDTH = 5;
    // x0 doubles as "no destination" in this core
    localparam logic [REG_WIDTH-1:0] RNONE = '0;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Purpose: pair of free-running stall/flush event counters, wrapping modulo 2^CNT_WIDTH.
// Latency: count visible one cycle after the enable.
// Backpressure: none; enables are sampled every cycle.
module hazard_perf_cnt #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_inc,
    input  logic                 flush_inc,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: stall/bubble controller for the 5-stage pipe (load-use, mispredict, dmem wait, halt).
// Latency: stall/bubble outputs are combinational from state + inputs; state/counters registered.
// Backpressure: a dmem miss freezes F..M and bubbles W until dmem_ready; halt freezes all stages.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter logic [6:0]  OP_LOAD   = pipe_hazard_ctrl_pkg::OP_LOAD,
    parameter logic [6:0]  OP_SYSTEM = pipe_hazard_ctrl_pkg::OP_SYSTEM
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [REG_WIDTH-1:0] D_rs1_i,
    input  logic [REG_WIDTH-1:0] D_rs2_i,
    input  logic [6:0]           E_opcode_i,
    input  logic [REG_WIDTH-1:0] E_dstM_i,
    input  logic                 e_mispredict_i,
    input  logic                 M_mem_req_i,
    input  logic                 dmem_ready_i,
    input  logic [6:0]           W_opcode_i,
    output logic                 F_stall_o,
    output logic                 D_stall_o,
    output logic                 E_stall_o,
    output logic                 M_stall_o,
    output logic                 W_stall_o,
    output logic                 D_bubble_o,
    output logic                 E_bubble_o,
    output logic                 M_bubble_o,
    output logic                 W_bubble_o,
    output logic                 halt_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    hz_state_t state, state_nxt;
    logic      load_use;
    logic      flush_hit;
    logic      stall_inc;

    assign load_use = (E_opcode_i == OP_LOAD) && (E_dstM_i != RNONE) && (E_dstM_i != '0) &&
                      ((E_dstM_i == D_rs1_i) || (E_dstM_i == D_rs2_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        F_stall_o  = 1'b0;
        D_stall_o  = 1'b0;
        E_stall_o  = 1'b0;
        M_stall_o  = 1'b0;
        W_stall_o  = 1'b0;
        D_bubble_o = 1'b0;
        E_bubble_o = 1'b0;
        M_bubble_o = 1'b0;
        W_bubble_o = 1'b0;
        flush_hit  = 1'b0;
        if (!rst_i) begin
            unique case (state)
                RUN: begin
                    if (W_opcode_i == OP_SYSTEM) begin
                        {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o} = 5'b11111;
                        state_nxt = HALT;
                    end else if (M_mem_req_i && !dmem_ready_i) begin
                        {F_stall_o, D_stall_o, E_stall_o, M_stall_o} = 4'b1111;
                        W_bubble_o = 1'b1;
                        state_nxt  = MEM_WAIT;
                    end else if (e_mispredict_i) begin
                        D_bubble_o = 1'b1;
                        E_bubble_o = 1'b1;
                        flush_hit  = 1'b1;
                    end else if (load_use) begin
                        F_stall_o  = 1'b1;
                        D_stall_o  = 1'b1;
                        E_bubble_o = 1'b1;
                    end
                end
                // E is frozen here, so mispredict/load-use wait for the next RUN cycle
                MEM_WAIT: begin
                    {F_stall_o, D_stall_o, E_stall_o, M_stall_o} = 4'b1111;
                    W_bubble_o = 1'b1;
                    if (dmem_ready_i) state_nxt = RUN;
                end
                HALT: begin
                    {F_stall_o, D_stall_o, E_stall_o, M_stall_o, W_stall_o} = 5'b11111;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign halt_o    = (state == HALT);
    assign stall_inc = F_stall_o && (state != HALT);

    hazard_perf_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_perf_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stall_inc (stall_inc),
        .flush_inc (flush_hit),
        .stall_cnt (stall_cnt_o),
        .flush_cnt (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; 4-bit counters so wrap is reachable.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic [4:0]    d_rs1, d_rs2, e_dst;
    logic [6:0]    e_op, w_op;
    logic          misp, mreq, rdy;
    logic          f_st, d_st, e_st, m_st, w_st;
    logic          d_bb, e_bb, m_bb, w_bb, halt;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [9:0]    outs;

    int n_vec = 0;
    int n_bad = 0;

    // {F,D,E,M,W stall, D,E,M,W bubble, halt}
    localparam logic [9:0] P_NONE = 10'b00000_0000_0;
    localparam logic [9:0] P_MEM  = 10'b11110_0001_0;
    localparam logic [9:0] P_MISP = 10'b00000_1100_0;
    localparam logic [9:0] P_LU   = 10'b11000_0100_0;
    localparam logic [9:0] P_SYS  = 10'b11111_0000_0;
    localparam logic [9:0] P_HALT = 10'b11111_0000_1;

    pipe_hazard_ctrl #(
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .D_rs1_i        (d_rs1),
        .D_rs2_i        (d_rs2),
        .E_opcode_i     (e_op),
        .E_dstM_i       (e_dst),
        .e_mispredict_i (misp),
        .M_mem_req_i    (mreq),
        .dmem_ready_i   (rdy),
        .W_opcode_i     (w_op),
        .F_stall_o      (f_st),
        .D_stall_o      (d_st),
        .E_stall_o      (e_st),
        .M_stall_o      (m_st),
        .W_stall_o      (w_st),
        .D_bubble_o     (d_bb),
        .E_bubble_o     (e_bb),
        .M_bubble_o     (m_bb),
        .W_bubble_o     (w_bb),
        .halt_o         (halt),
        .stall_cnt_o    (stall_cnt),
        .flush_cnt_o    (flush_cnt)
    );

    assign outs = {f_st, d_st, e_st, m_st, w_st, d_bb, e_bb, m_bb, w_bb, halt};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // E never holds a branch and a load-use producer at once
    always @(negedge clk) begin
        if (!rst && misp && e_op == 7'h03 && e_dst != 5'd0 && (e_dst == d_rs1 || e_dst == d_rs2))
            $error("illegal input: mispredict with load-use in E");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive -> sample at negedge -> advance past the next posedge
    task automatic step(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, {22'd0, outs}, {22'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic cnt(input string tag, input logic [CW-1:0] s, input logic [CW-1:0] f);
        check({tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, s});
        check({tag, "_flush_cnt"}, {28'd0, flush_cnt}, {28'd0, f});
    endtask

    initial begin
        rst = 1'b1; mreq = 1'b1; rdy = 1'b0; misp = 1'b0;
        e_op = 7'h00; e_dst = 5'd0; d_rs1 = 5'd0; d_rs2 = 5'd0; w_op = 7'h00;

        step("reset_c1", P_NONE);
        step("reset_c2", P_NONE);
        cnt("reset", 0, 0);

        // miss held through release: RUN cycle + 3 wait cycles
        rst = 1'b0;
        step("mem_run", P_MEM);
        step("mem_w1", P_MEM);
        step("mem_w2", P_MEM);
        rdy = 1'b1;
        step("mem_done", P_MEM);
        mreq = 1'b0; rdy = 1'b0;
        step("mem_exit", P_NONE);
        cnt("mem", 4, 0);

        mreq = 1'b1; rdy = 1'b1;
        step("mem_hit", P_NONE);
        mreq = 1'b0; rdy = 1'b0;

        e_op = 7'h03; e_dst = 5'd5; d_rs1 = 5'd3; d_rs2 = 5'd5;
        step("lu_rs2", P_LU);
        cnt("lu_rs2", 5, 0);
        e_dst = 5'd0;
        step("lu_x0", P_NONE);
        e_dst = 5'd3;
        step("lu_rs1", P_LU);
        e_op = 7'h13;
        step("lu_notload", P_NONE);
        cnt("lu", 6, 0);
        e_op = 7'h00; e_dst = 5'd0;

        misp = 1'b1;
        step("misp", P_MISP);
        misp = 1'b0;
        cnt("misp", 6, 1);

        // mispredict pending across a dmem wait flushes once, after the wait
        misp = 1'b1; mreq = 1'b1; rdy = 1'b0;
        step("mm_run", P_MEM);
        step("mm_w1", P_MEM);
        rdy = 1'b1;
        step("mm_w2", P_MEM);
        mreq = 1'b0; rdy = 1'b0;
        step("mm_flush", P_MISP);
        misp = 1'b0;
        step("mm_idle", P_NONE);
        cnt("mm", 9, 2);

        mreq = 1'b1; rdy = 1'b0;
        step("rw_run", P_MEM);
        step("rw_w1", P_MEM);
        rst = 1'b1;
        step("rw_rst", P_NONE);
        rst = 1'b0; rdy = 1'b1;
        step("rw_after", P_NONE);
        cnt("rw", 0, 0);
        mreq = 1'b0; rdy = 1'b0;

        // 17 stall cycles on a 4-bit counter
        mreq = 1'b1;
        for (int i = 0; i < 16; i++) step("wrap", P_MEM);
        rdy = 1'b1;
        step("wrap_last", P_MEM);
        mreq = 1'b0; rdy = 1'b0;
        step("wrap_idle", P_NONE);
        cnt("wrap", 1, 0);

        misp = 1'b1;
        step("pre_halt_misp", P_MISP);
        cnt("pre_halt", 1, 1);
        w_op = 7'h73;
        step("sys_run", P_SYS);
        w_op = 7'h00; mreq = 1'b1; rdy = 1'b0;
        step("halt1", P_HALT);
        rdy = 1'b1;
        step("halt2", P_HALT);
        cnt("halt", 2, 1);

        rst = 1'b1;
        @(negedge clk);
        check("halt_rst_outs", {23'd0, outs[9:1]}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; misp = 1'b0; mreq = 1'b0; rdy = 1'b0;
        step("post_halt", P_NONE);
        cnt("post_halt", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
